// File: rtl/btn_set_ctrl.sv
// btn_set_ctrl: time-set controller for the 7-segment clock.
// Turns debounced MODE/ADJ levels into the RUN -> SET_HR -> SET_MIN mode
// sequence and emits one-cycle increment pulses with long-press auto-repeat.
// An idle timeout returns the controller to RUN.
//
// Ports:
//   i_clk      - single clock
//   i_rst_n    - asynchronous active-low reset
//   i_mode     - debounced MODE level
//   i_adj      - debounced ADJ level
//   o_inc_hr   - one-cycle hour increment pulse
//   o_inc_min  - one-cycle minute increment pulse
//   o_sec_clr  - one-cycle seconds clear on entry to SET_HR
//   o_mode     - current state: 0 RUN, 1 SET_HR, 2 SET_MIN
//   o_hold     - high while not in RUN (freezes seconds)
module btn_set_ctrl #(
  parameter int unsigned LONG_PRESS    = 5_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_000_000,
  parameter int unsigned IDLE_TIMEOUT  = 100_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_mode,
  input  logic       i_adj,
  output logic       o_inc_hr,
  output logic       o_inc_min,
  output logic       o_sec_clr,
  output logic [1:0] o_mode,
  output logic       o_hold
);

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_PRESS - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] IdleLast   = CNT_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun = 2'd0, StSetHr = 2'd1, StSetMin = 2'd2} state_e;
  typedef enum logic [1:0] {PhIdle, PhWait, PhRepeat, PhLocked} phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             mode_s_q, mode_p_q, adj_s_q, adj_p_q, primed_q;
  logic             inc_hr_q, inc_min_q, sec_clr_q;
  logic             inc_hr_d, inc_min_d, sec_clr_d;
  logic             mode_rise, adj_rise, in_set, inc_pulse, timeout;

  // Sampled level (s) and its previous value (p). Until primed, p tracks the
  // input directly so a button held through reset never looks like a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_s_q <= 1'b0;
      mode_p_q <= 1'b0;
      adj_s_q  <= 1'b0;
      adj_p_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      mode_s_q <= i_mode;
      adj_s_q  <= i_adj;
      mode_p_q <= primed_q ? mode_s_q : i_mode;
      adj_p_q  <= primed_q ? adj_s_q : i_adj;
      primed_q <= 1'b1;
    end
  end

  assign mode_rise = primed_q & mode_s_q & ~mode_p_q;
  assign adj_rise  = primed_q & adj_s_q & ~adj_p_q;
  assign in_set    = (state_q == StSetHr) || (state_q == StSetMin);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hold_cnt_d = hold_cnt_q;
    inc_pulse  = 1'b0;
    sec_clr_d  = 1'b0;
    timeout    = 1'b0;
    if (mode_rise) begin
      // MODE wins over any ADJ activity; a held ADJ must be re-pressed.
      unique case (state_q)
        StRun: begin
          state_d   = StSetHr;
          sec_clr_d = 1'b1;
        end
        StSetHr: state_d = StSetMin;
        default: state_d = StRun;
      endcase
      phase_d    = adj_s_q ? PhLocked : PhIdle;
      hold_cnt_d = '0;
    end else if (in_set && (idle_cnt_q == IdleLast)) begin
      timeout    = 1'b1;
      state_d    = StRun;
      phase_d    = adj_s_q ? PhLocked : PhIdle;
      hold_cnt_d = '0;
    end else if (!adj_s_q) begin
      phase_d    = PhIdle;
      hold_cnt_d = '0;
    end else if (in_set) begin
      unique case (phase_q)
        PhIdle: begin
          if (adj_rise) begin
            inc_pulse  = 1'b1;
            hold_cnt_d = '0;
            phase_d    = PhWait;
          end
        end
        PhWait: begin
          if (hold_cnt_q == LongLast) begin
            inc_pulse  = 1'b1;
            hold_cnt_d = '0;
            phase_d    = PhRepeat;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        PhRepeat: begin
          if (hold_cnt_q == RepeatLast) begin
            inc_pulse  = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: hold_cnt_d = '0;
      endcase
    end

    inc_hr_d  = inc_pulse && (state_q == StSetHr);
    inc_min_d = inc_pulse && (state_q == StSetMin);

    if (mode_rise || inc_pulse || timeout || !in_set) begin
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StRun;
      phase_q    <= PhIdle;
      hold_cnt_q <= '0;
      idle_cnt_q <= '0;
      inc_hr_q   <= 1'b0;
      inc_min_q  <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hold_cnt_q <= hold_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      inc_hr_q   <= inc_hr_d;
      inc_min_q  <= inc_min_d;
      sec_clr_q  <= sec_clr_d;
    end
  end

  assign o_inc_hr  = inc_hr_q;
  assign o_inc_min = inc_min_q;
  assign o_sec_clr = sec_clr_q;
  assign o_mode    = state_q;
  assign o_hold    = (state_q != StRun);

endmodule

// File: tb/tb_btn_set_ctrl.sv
// Bench for btn_set_ctrl: directed scenarios followed by random button
// traffic. A timestamp-based reference model pushes expected output events
// into a queue; a monitor pops and compares whenever the DUT shows activity.
module tb_btn_set_ctrl;

  localparam int LP = 8;
  localparam int RP = 4;
  localparam int IT = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_mode = 1'b0;
  logic       i_adj = 1'b0;
  logic       inc_hr, inc_min, sec_clr, hold;
  logic [1:0] mode;

  btn_set_ctrl #(
    .LONG_PRESS   (LP),
    .REPEAT_PERIOD(RP),
    .IDLE_TIMEOUT (IT),
    .CNT_W        (8)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_mode   (i_mode),
    .i_adj    (i_adj),
    .o_inc_hr (inc_hr),
    .o_inc_min(inc_min),
    .o_sec_clr(sec_clr),
    .o_mode   (mode),
    .o_hold   (hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit hr;
    bit mn;
    bit sc;
    int mode;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  bit  in_reset = 1'b1;
  int  sc_seen = 0;
  int  hr_seen = 0;
  int  mn_seen = 0;

  // Reference model state (timestamps in posedge counts).
  int  md_mode = 0;
  bit  md_armed = 0;
  int  md_press = 0;
  int  md_last = 0;
  bit  md_first = 1;
  bit  md_m_prev = 0;
  bit  md_a_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Levels m/a are sampled at one edge; the resulting output shows at edge e.
  task automatic model_step(input bit m, input bit a, input int e);
    bit m_rise, a_rise, pulse, hr, mn, sc, ev;
    int d;
    m_rise = !md_first && m && !md_m_prev;
    a_rise = !md_first && a && !md_a_prev;
    md_first = 0;
    md_m_prev = m;
    md_a_prev = a;
    pulse = 0; hr = 0; mn = 0; sc = 0; ev = 0;
    if (m_rise) begin
      if (md_mode == 0) sc = 1;
      md_mode = (md_mode + 1) % 3;
      md_armed = 0;
      md_last = e;
      ev = 1;
    end else if (md_mode != 0 && e - md_last == IT) begin
      md_mode = 0;
      md_armed = 0;
      ev = 1;
    end else if (!a) begin
      md_armed = 0;
    end else if (md_mode != 0) begin
      if (a_rise) begin
        md_armed = 1;
        md_press = e;
        pulse = 1;
      end else if (md_armed) begin
        d = e - md_press;
        if (d == LP || (d > LP && (d - LP) % RP == 0)) pulse = 1;
      end
      if (pulse) begin
        md_last = e;
        ev = 1;
        hr = (md_mode == 1);
        mn = (md_mode == 2);
      end
    end
    if (ev) q.push_back('{e, hr, mn, sc, md_mode});
  endtask

  task automatic drive(input bit m, input bit a, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_mode = m;
      i_adj = a;
      model_step(m, a, cyc + 2);
    end
  endtask

  task automatic reset_pulse(input bit m, input bit a, input int n);
    @(negedge clk);
    rst_n = 1'b0;
    in_reset = 1'b1;
    i_mode = m;
    i_adj = a;
    q.delete();
    #1;
    chk("rst_immediate", {inc_hr, inc_min, sec_clr, mode, hold}, 0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    md_mode = 0;
    md_armed = 0;
    md_first = 1;
    model_step(i_mode, i_adj, cyc + 2);
  endtask

  // Monitor
  int mon_mode = 0;
  always @(posedge clk) begin
    ev_t e;
    bit  due;
    #1;
    if (inc_hr) hr_seen++;
    if (inc_min) mn_seen++;
    if (sec_clr) sc_seen++;
    if (in_reset) begin
      mon_mode = 0;
      chk("rst_outputs", {inc_hr, inc_min, sec_clr, mode, hold}, 0);
    end else begin
      due = (q.size() > 0) && (q[0].cyc <= cyc);
      if (due || inc_hr || inc_min || sec_clr || (int'(mode) != mon_mode)) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {inc_hr, inc_min, sec_clr, mode}, {3'b000, 2'(mon_mode)});
        end else begin
          e = q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("inc_hr", inc_hr, e.hr);
          chk("inc_min", inc_min, e.mn);
          chk("sec_clr", sec_clr, e.sc);
          chk("mode", mode, e.mode);
          mon_mode = e.mode;
        end
      end
      chk("hold", hold, mon_mode != 0);
    end
  end

  initial begin
    bit m, a;
    int n;
    #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    md_first = 1;
    model_step(1'b0, 1'b0, cyc + 2);
    drive(0, 0, 3);

    // Four MODE taps: 1, 2, 0, 1 with two seconds clears.
    sc_seen = 0;
    repeat (4) begin
      drive(1, 0, 3);
      drive(0, 0, 3);
    end
    chk("sec_clr_count", sc_seen, 2);
    chk("mode_after_taps", mode, 1);

    // Long press in SET_HR.
    hr_seen = 0;
    mn_seen = 0;
    drive(0, 1, 20);
    drive(0, 0, 3);
    chk("long_press_hr", hr_seen, 4);
    chk("long_press_min", mn_seen, 0);

    // Back to RUN, ADJ tap ignored.
    drive(1, 0, 2); drive(0, 0, 2);
    drive(1, 0, 2); drive(0, 0, 2);
    drive(0, 1, 3); drive(0, 0, 3);

    // Held ADJ across a mode change, then release and re-press.
    drive(1, 0, 2); drive(0, 0, 2);
    drive(0, 1, 5);
    drive(1, 1, 3);
    mn_seen = 0;
    drive(0, 1, 12);
    chk("locked_no_min", mn_seen, 0);
    drive(0, 0, 2);
    drive(0, 1, 2);
    drive(0, 0, 2);
    chk("repress_one_min", mn_seen, 1);

    // Idle timeout from SET_MIN.
    drive(0, 0, 40);
    chk("timeout_mode", mode, 0);

    // Reset mid-repeat in SET_MIN with both buttons held through release.
    drive(1, 0, 2); drive(0, 0, 2);
    drive(1, 0, 2); drive(0, 0, 2);
    drive(0, 1, 15);
    reset_pulse(1, 1, 3);
    drive(1, 1, 8);
    chk("held_thru_rst", mode, 0);
    drive(0, 0, 3);
    drive(1, 0, 2);
    drive(0, 1, 3);
    drive(0, 0, 3);

    // Random traffic.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(39) == 0) begin
        reset_pulse(1'($urandom_range(1)), 1'($urandom_range(1)), 1 + $urandom_range(2));
      end else begin
        m = ($urandom_range(4) == 0);
        a = 1'($urandom_range(1));
        n = m ? 1 + $urandom_range(2) : 1 + $urandom_range(39);
        drive(m, a, n);
      end
    end

    drive(0, 0, 40);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_set_ctrl.md
# btn_set_ctrl

Time-set controller for the 7-segment clock. Consumes the debounced MODE and ADJ button levels and runs the RUN / SET_HR / SET_MIN mode sequence. It emits single-cycle increment pulses for the hour and minute counters, with long-press auto-repeat and an idle timeout back to RUN. It sits between the two button debouncers and the timekeeping/display datapath.

## Interface
Parameters:
- LONG_PRESS, 5_000_000: cycles ADJ must be held after its first pulse before auto-repeat begins (0.5 s at 10 MHz).
- REPEAT_PERIOD, 2_000_000: cycles between auto-repeat pulses (0.2 s).
- IDLE_TIMEOUT, 100_000_000: cycles without activity in a SET state before forced return to RUN (10 s).
- CNT_W, 27: width of the internal hold and idle counters. All three periods must fit in CNT_W bits and be ≥ 2.

Ports:
- i_clk, in, 1: single clock, 10 MHz.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_mode, in, 1: debounced MODE level, synchronous to i_clk.
- i_adj, in, 1: debounced ADJ level, synchronous to i_clk.
- o_inc_hr, out, 1: one-cycle pulse that increments hours.
- o_inc_min, out, 1: one-cycle pulse that increments minutes.
- o_sec_clr, out, 1: one-cycle pulse that zeroes seconds on entry to SET_HR.
- o_mode, out, 2: current state. 0 = RUN, 1 = SET_HR, 2 = SET_MIN. Code 3 is unused.
- o_hold, out, 1: high when o_mode ≠ RUN. The timekeeper freezes its seconds count while this is high.

## Operation
- Edge detect: previous-level registers for i_mode and i_adj; rise = level & ~prev.
- After reset, a `primed` flag is 0 for the first clock. While it is 0, rises are suppressed, so a button held through reset produces nothing.
- State transitions on a MODE rise:
  - RUN → SET_HR, with o_sec_clr pulsed.
  - SET_HR → SET_MIN.
  - SET_MIN → RUN.
- ADJ in RUN: ignored; no pulses.
- ADJ in SET_HR / SET_MIN: each pulse goes to o_inc_hr or o_inc_min respectively.
  - Rise: one pulse immediately; hold counter loads 0; phase = WAIT.
  - WAIT, still held: counter increments. When it reaches LONG_PRESS-1: pulse, counter reset to 0, phase = REPEAT.
  - REPEAT, still held: a pulse each time the counter reaches REPEAT_PERIOD-1; counter reset to 0.
  - ADJ low: phase = IDLE, counter held at 0.
- Simultaneous MODE rise and any ADJ activity: MODE wins. The state changes, no inc pulse is issued that cycle, and the ADJ phase is set to LOCKED.
  - LOCKED persists until ADJ is sampled low.
  - An ADJ held across a mode change never generates pulses in the new state; a re-press is required.
- Idle timer: cleared on every MODE rise, every inc pulse, and whenever o_mode = RUN.
  - In SET states it increments every cycle. On reaching IDLE_TIMEOUT-1 it forces state = RUN and ADJ phase = LOCKED if ADJ is high.
  - A MODE rise in that same cycle takes priority; the timeout is ignored.
- Never more than one of o_inc_hr, o_inc_min, o_sec_clr is high in any cycle.
- Counters saturate-free: they are always reloaded before wrap, given the parameter constraint.

## Timing
- Reset values (asynchronous, i_rst_n low):
  - o_mode = 0, o_hold = 0.
  - o_inc_hr = o_inc_min = o_sec_clr = 0.
  - All counters 0, prev registers 0, primed 0, ADJ phase IDLE.
- Reset asserted mid-operation: everything returns to the reset values immediately. Any pulse in flight is dropped.
- All outputs are registered. Latency is one cycle.
  - For a level first sampled high at edge N (low at N-1), the pulse or state change is visible after edge N+1.
- Long press with ADJ rising at edge N:
  - First pulse at cycle N+1.
  - Second pulse at N+1+LONG_PRESS.
  - Subsequent pulses every REPEAT_PERIOD cycles.
- Timeout: with the last activity at edge M, o_mode = 0 after edge M+IDLE_TIMEOUT.
- o_hold follows o_mode in the same cycle (combinational decode of the state register).

## Test plan
Bench parameters: LONG_PRESS=8, REPEAT_PERIOD=4, IDLE_TIMEOUT=32, CNT_W=8.
- Four MODE taps (each 3 cycles high, 3 low) from RUN → o_mode 1, 2, 0, 1. o_sec_clr pulses exactly once per RUN → SET_HR entry.
- SET_HR, ADJ held 20 cycles → o_inc_hr pulses at cycles +1, +9, +13, +17 relative to the rise; o_inc_min stays 0.
- ADJ tap in RUN → no inc pulses; o_mode stays 0; o_hold stays 0.
- ADJ held, then MODE rise while in SET_HR → o_mode = 2 with no inc pulse that cycle. No o_inc_min pulse until ADJ is released and re-pressed; the re-press yields exactly one pulse.
- SET_MIN with no activity → o_mode returns to 0 exactly 32 cycles after the last event.
- i_rst_n pulsed low mid-repeat in SET_MIN → all outputs 0 immediately. With ADJ and MODE held through reset release, no pulse and no state change occur until they are released and re-pressed.
